// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states,
// latched request record and decode helpers.
package load_store_unit_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      LSU_B, LSU_H, LSU_W: return 1'b1;
      LSU_BU, LSU_HU:      return !we;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      LSU_H, LSU_HU: return a[0];
      LSU_W:         return a != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed memory bus with byte enables and a req/ack handshake.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store data replication and byte enables, load
// byte/half extraction with sign or zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data
);

  logic [NUM_LANES-1:0][7:0] lanes;
  logic [7:0]                b;
  logic [15:0]               h;

  assign lanes = rword;
  assign b     = lanes[addr_lo];
  // addr_lo[0] is deliberately ignored for halves
  assign h     = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    st_wdata = wdata;
    st_be    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{wdata[7:0]}};
        st_be    = 4'b0001 << addr_lo;
      end
      2'b01: begin
        st_wdata = {2{wdata[15:0]}};
        st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = rword;
    case (funct3)
      LSU_B:   ld_data = {{24{b[7]}}, b};
      LSU_H:   ld_data = {{16{h[15]}}, h};
      LSU_BU:  ld_data = {24'd0, b};
      LSU_HU:  ld_data = {16'd0, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE->BUSY->RESP FSM, request latch and bus timeout.
// Optional MISALIGN_TRAP_EN turns misaligned H/W accesses into error responses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [2:0]         cpu_funct3,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_stall,
  output logic               cpu_done,
  output logic               cpu_err,
  output logic               cpu_misalign,
  load_store_unit_if.master  mem
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  lsu_state_e  state, state_nxt;
  lsu_req_t    req_q;
  logic        err_q, mis_q;
  logic [31:0] rdata_q;
  logic [7:0]  cnt;
  logic        bad_f3, bad_align, timeout, busy;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_be;

  assign bad_f3 = !f3_legal(cpu_we, cpu_funct3);
`ifdef MISALIGN_TRAP_EN
  assign bad_align = !bad_f3 && misaligned(cpu_funct3, cpu_addr[1:0]);
`else
  assign bad_align = 1'b0;
`endif

  assign busy    = (state == LSU_BUSY);
  assign timeout = busy && (TO_LIM != 8'd0) && (cnt == TO_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: if (cpu_req) state_nxt = (bad_f3 || bad_align) ? LSU_RESP : LSU_BUSY;
      LSU_BUSY: if (timeout || mem.mem_ack) state_nxt = LSU_RESP;
      LSU_RESP: state_nxt = LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        LSU_IDLE: if (cpu_req) begin
          req_q   <= '{we: cpu_we, funct3: cpu_funct3, addr: cpu_addr, wdata: cpu_wdata};
          err_q   <= bad_f3 || bad_align;
          mis_q   <= bad_align;
          rdata_q <= '0;
          cnt     <= '0;
        end
        LSU_BUSY: begin
          // abort wins over a same-cycle ack: mem_req is already low then
          if (timeout) err_q <= 1'b1;
          else begin
            if (mem.mem_ack && !req_q.we) rdata_q <= mem.mem_rdata;
            if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  lsu_align u_align (
    .funct3   (req_q.funct3),
    .addr_lo  (req_q.addr[1:0]),
    .wdata    (req_q.wdata),
    .rword    (rdata_q),
    .st_wdata (st_wdata),
    .st_be    (st_be),
    .ld_data  (ld_data)
  );

  assign cpu_done     = (state == LSU_RESP);
  assign cpu_err      = cpu_done && err_q;
  assign cpu_misalign = cpu_done && mis_q;
  assign cpu_stall    = cpu_req && !cpu_done;
  assign cpu_rdata    = (cpu_done && !err_q) ? ld_data : 32'd0;

  assign mem.mem_req   = busy && !timeout;
  assign mem.mem_we    = busy && req_q.we;
  assign mem.mem_addr  = busy ? {req_q.addr[31:2], 2'b00} : 32'd0;
  assign mem.mem_be    = !busy ? 4'd0 : (req_q.we ? st_be : 4'b1111);
  assign mem.mem_wdata = (busy && req_q.we) ? st_wdata : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors then random
// accesses against a byte-array memory model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_done, cpu_err, cpu_misalign;

  load_store_unit_if mem_bus();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_funct3   (cpu_funct3),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .cpu_done     (cpu_done),
    .cpu_err      (cpu_err),
    .cpu_misalign (cpu_misalign),
    .mem          (mem_bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  ref_bytes [1024];
  logic [31:0] sim_mem [256];

  int          o_lat, o_nreq;
  logic [31:0] o_rdata, o_addr, o_wd;
  logic [3:0]  o_be;
  logic        o_err, o_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference read: little-endian assemble of size bytes, then extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int base, input int size);
    logic [31:0] v = 0;
    for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[(base + i) & 1023]) << (8 * i));
    if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  // One access from request to the cycle after done; called at a negedge.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int dly, input bit ack_en);
    bit          legal, mis, trap, got;
    int          size, off, base, k, nreq, e_lat, e_nreq;
    logic        e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    logic [31:0] wbytes;
    legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) || (!we && (f3 == 3'b100 || f3 == 3'b101));
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis   = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
    trap = legal && mis;
`else
    trap = 1'b0;
`endif
    off    = (size == 1) ? int'(addr[1:0]) : (size == 2) ? (addr[1] ? 2 : 0) : 0;
    base   = int'(addr[9:0]) & ~3;
    e_err  = !legal || trap || !ack_en;
    e_lat  = (!legal || trap) ? 1 : (!ack_en ? TO + 2 : dly + 2);
    e_nreq = (!legal || trap) ? 0 : (!ack_en ? TO : dly + 1);
    e_be   = 0;
    e_wd   = 0;
    wbytes = wd;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) e_be[i] = 1'b1;
      e_wd[8*i +: 8] = wbytes[8*(i % size) +: 8];
    end
    if (!we) e_be = 4'b1111;
    e_rd = (e_err || we) ? 32'd0 : ref_load(f3, base + off, size);

    cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wd;
    k = 0; nreq = 0; got = 0;
    o_addr = 0; o_be = 0; o_wd = 0; o_rdata = 0; o_err = 0; o_mis = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      mem_bus.mem_ack = 1'b0;
      if (cpu_done) begin
        got = 1; o_rdata = cpu_rdata; o_err = cpu_err; o_mis = cpu_misalign;
        chk("stall_at_done", cpu_stall, 0);
      end else begin
        chk("stall", cpu_stall, 1);
        if (mem_bus.mem_req) begin
          nreq++;
          if (nreq == 1) begin
            o_addr = mem_bus.mem_addr; o_be = mem_bus.mem_be; o_wd = mem_bus.mem_wdata;
            chk("mem_we", mem_bus.mem_we, we);
          end else begin
            chk("addr_stable", mem_bus.mem_addr, o_addr);
            chk("be_stable", mem_bus.mem_be, o_be);
          end
          if (ack_en && nreq > dly) begin
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = sim_mem[mem_bus.mem_addr[9:2]];
            if (mem_bus.mem_we)
              for (int i = 0; i < 4; i++)
                if (mem_bus.mem_be[i]) sim_mem[mem_bus.mem_addr[9:2]][8*i +: 8] = mem_bus.mem_wdata[8*i +: 8];
          end
        end
      end
    end
    o_lat = k; o_nreq = nreq;
    cpu_req = 1'b0;
    chk("done_seen", got, 1);
    chk("latency", o_lat, e_lat);
    chk("nreq", o_nreq, e_nreq);
    chk("err", o_err, e_err);
    chk("misalign", o_mis, trap);
    if (!we || e_err) chk("rdata", o_rdata, e_rd);
    if (e_nreq > 0) begin
      chk("mem_addr", o_addr, {addr[31:2], 2'b00});
      chk("mem_be", o_be, e_be);
      if (we) chk("mem_wdata", o_wd, e_wd);
    end
    if (we && !e_err)
      for (int i = 0; i < size; i++) ref_bytes[(base + off + i) & 1023] = wbytes[8*i +: 8];
    @(negedge clk);
    chk("done_pulse", cpu_done, 0);
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_funct3 = 0; cpu_addr = 0; cpu_wdata = 0;
    mem_bus.mem_ack = 0; mem_bus.mem_rdata = 0;
    for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'($urandom);
    for (int i = 0; i < 256; i++)
      sim_mem[i] = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_bus.mem_req, 0);
    chk("rst_mem_be", mem_bus.mem_be, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_stall", cpu_stall, 0);
    rst_n = 1'b1;
    @(negedge clk);

    access(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1);
    chk("sw_be", o_be, 4'b1111);
    chk("sw_lat", o_lat, 2);
    access(1, 3'b000, 32'h103, 32'h000000A5, 0, 1);
    chk("sb_wdata", o_wd, 32'hA5A5A5A5);
    chk("sb_be", o_be, 4'b1000);
    access(0, 3'b000, 32'h103, 0, 1, 1);
    chk("lb_val", o_rdata, 32'hFFFFFFA5);
    access(1, 3'b010, 32'h100, 32'h80011234, 0, 1);
    access(0, 3'b101, 32'h102, 0, 0, 1);
    chk("lhu_val", o_rdata, 32'h00008001);
    access(0, 3'b001, 32'h102, 0, 2, 1);
    chk("lh_val", o_rdata, 32'hFFFF8001);
    access(0, 3'b010, 32'h100, 0, 3, 1);
    chk("lw_wait_nreq", o_nreq, 4);
    chk("lw_wait_val", o_rdata, 32'h80011234);
    access(1, 3'b100, 32'h100, 32'h1, 0, 1);
    chk("illegal_err", o_err, 1);

    access(0, 3'b010, 32'h200, 0, 0, 0);
    chk("to_nreq", o_nreq, TO);
    chk("to_rdata", o_rdata, 0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("late_ack_done", cpu_done, 0);
    chk("late_ack_req", mem_bus.mem_req, 0);
    mem_bus.mem_ack = 1'b0;

    access(0, 3'b010, 32'h102, 0, 0, 1);
`ifdef MISALIGN_TRAP_EN
    chk("mis_lw_flag", o_mis, 1);
    chk("mis_lw_nreq", o_nreq, 0);
`else
    chk("mis_lw_addr", o_addr, 32'h100);
    chk("mis_lw_val", o_rdata, 32'h80011234);
`endif

    cpu_req = 1; cpu_we = 0; cpu_funct3 = 3'b010; cpu_addr = 32'h104;
    @(negedge clk);
    chk("rst_busy_req", mem_bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_abort_req", mem_bus.mem_req, 0);
    chk("rst_abort_done", cpu_done, 0);
    cpu_req = 0; mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("post_rst_req", mem_bus.mem_req, 0);
    chk("post_rst_done", cpu_done, 0);
    access(0, 3'b010, 32'h104, 0, 1, 1);

    for (int t = 0; t < 80; t++) begin
      int r;
      r = $urandom_range(0, 9);
      access(1'($urandom_range(0, 1)), (r < 8) ? 3'(r) : 3'b010, $urandom, $urandom,
             $urandom_range(0, 2), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
